// File: rtl/bcd_display_pkg.sv
// Shared constants for the BCD display counter: segment encodings, key bit
// positions and default bus addresses.
package bcd_display_pkg;

    localparam logic [31:0] KEY_ADDR_DEF  = 32'hF000_0000;
    localparam logic [31:0] DISP_BASE_DEF = 32'hF000_0010;

    localparam int KEY_CLEAR = 0;
    localparam int KEY_STOP  = 1;
    localparam int KEY_START = 2;
    localparam int KEY_DOWN  = 3;

    localparam logic [7:0] SEG_ERR = 8'h79;

    // Active-high gfedcba codes, digit 0 in the low byte.
    localparam logic [79:0] SEG_TABLE = {8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
                                         8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};

    function automatic logic [7:0] seg_code(input logic [3:0] digit);
        logic [7:0] code;
        if (digit <= 4'd9) begin
            code = SEG_TABLE[{digit, 3'b000} +: 8];
        end else begin
            code = SEG_ERR;
        end
        return code;
    endfunction

endpackage

// File: rtl/bcd_display_counter_digit.sv
// One BCD decade with carry/borrow chaining. Carry out is combinational so a
// whole chain of decades updates on the same clock edge.
module bcd_digit
    import bcd_display_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       down_i,
    output logic [3:0] digit_o,
    output logic       carry_o
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;
    logic       at_limit_s;

    // Illegal codes above 9 are treated as the top of the decade when counting up.
    always_comb begin
        if (down_i) begin
            at_limit_s = (digit_q == 4'd0);
        end else begin
            at_limit_s = (digit_q >= 4'd9);
        end
    end

    // Next digit value: clear beats count.
    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = 4'd0;
        end else if (en_i) begin
            if (at_limit_s) begin
                digit_d = down_i ? 4'd9 : 4'd0;
            end else begin
                digit_d = down_i ? (digit_q - 4'd1) : (digit_q + 4'd1);
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign carry_o = en_i & at_limit_s;

endmodule

// File: rtl/bcd_display_counter.sv
// Multi-digit BCD counter with key-port control and a round-robin writer that
// pushes changed segment words to the display. Define BCD_COUNTER_DOWN_EN to
// enable down counting from key bit 3.
module bcd_display_counter
    import bcd_display_pkg::*;
#(
    parameter int          NUM_DIGITS = 10,
    parameter int          PRESCALE   = 1,
    parameter logic [31:0] KEY_ADDR   = KEY_ADDR_DEF,
    parameter logic [31:0] DISP_BASE  = DISP_BASE_DEF
) (
    input  logic                    wClk,
    input  logic                    nwReset,
    output logic                    wWrite,
    output logic [31:0]             bWriteAddr,
    output logic [31:0]             bWriteData,
    output logic [3:0]              bWriteMask,
    output logic                    wRead,
    output logic [31:0]             bReadAddr,
    input  logic [31:0]             bReadData,
    output logic [4*NUM_DIGITS-1:0] bCountBcd,
    output logic                    wCountOverflow
);

    localparam int          NUM_WORDS  = (NUM_DIGITS + 3) / 4;
    localparam int          PADW       = 16 * NUM_WORDS;
    localparam int          RW         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [16:0] PRESC_LAST = 17'(PRESCALE - 1);

    logic [3:0]              keys_q, keys_d;
    logic                    run_q, run_d;
    logic [16:0]             presc_q, presc_d;
    logic                    clr_s, tick_s, down_s;
    logic [NUM_DIGITS:0]     carry_s;
    logic [4*NUM_DIGITS-1:0] count_s;
    logic [PADW-1:0]         count_pad_s;
    logic [PADW-1:0]         prev_q, prev_d;
    logic [NUM_WORDS-1:0]    dirty_q, dirty_d, set_s, clr_word_s;
    logic [RW-1:0]           rr_q, rr_d, sel_s;
    logic                    found_s;
    logic [31:0]             sel_data_s;
    logic [3:0]              sel_mask_s;
    logic                    write_q, write_d;
    logic [31:0]             addr_q, addr_d, data_q, data_d;
    logic [3:0]              mask_q, mask_d;
    logic                    ovf_q, ovf_d;
    logic                    unused_s;

    assign clr_s  = keys_q[KEY_CLEAR];
`ifdef BCD_COUNTER_DOWN_EN
    assign down_s   = keys_q[KEY_DOWN];
    assign unused_s = ^bReadData[31:4];
`else
    assign down_s   = 1'b0;
    assign unused_s = ^{bReadData[31:4], keys_q[KEY_DOWN]};
`endif

    // Run flag and prescaler; a pending clear suppresses the tick.
    always_comb begin
        keys_d  = bReadData[3:0];
        run_d   = run_q;
        presc_d = presc_q;
        if (clr_s) begin
            run_d = 1'b0;
        end else if (keys_q[KEY_STOP]) begin
            run_d = 1'b0;
        end else if (keys_q[KEY_START]) begin
            run_d = 1'b1;
        end else begin
            run_d = run_q;
        end
        if (clr_s) begin
            presc_d = 17'd0;
        end else if (run_q) begin
            presc_d = (presc_q == PRESC_LAST) ? 17'd0 : (presc_q + 17'd1);
        end else begin
            presc_d = presc_q;
        end
        tick_s = run_q & ~clr_s & (presc_q == PRESC_LAST);
    end

    assign carry_s[0] = tick_s;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk     (wClk),
            .rst_n   (nwReset),
            .clr_i   (clr_s),
            .en_i    (carry_s[g]),
            .down_i  (down_s),
            .digit_o (count_s[4*g +: 4]),
            .carry_o (carry_s[g+1])
        );
    end

    assign count_pad_s = PADW'(count_s);
    assign ovf_d       = carry_s[NUM_DIGITS];
    assign prev_d      = count_pad_s;

    // A word becomes dirty when any of its digits changed on the previous edge.
    always_comb begin
        set_s = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            set_s[k] = (count_pad_s[16*k +: 16] != prev_q[16*k +: 16]);
        end
    end

    // Fair pick: first dirty word at or after rr_q, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        found_s = 1'b0;
        sel_s   = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_WORDS) begin
                idx = idx - NUM_WORDS;
            end else begin
                idx = idx;
            end
            if (!found_s && dirty_q[idx]) begin
                found_s = 1'b1;
                sel_s   = RW'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Segment data and byte mask for the selected word; bytes past the last digit stay 0.
    always_comb begin
        int d;
        d          = 0;
        sel_data_s = 32'd0;
        sel_mask_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            d = int'(sel_s) * 4 + i;
            if (d < NUM_DIGITS) begin
                sel_data_s[8*i +: 8] = seg_code(count_pad_s[4*d +: 4]);
                sel_mask_s[i]        = 1'b1;
            end else begin
                sel_data_s[8*i +: 8] = 8'h00;
                sel_mask_s[i]        = 1'b0;
            end
        end
    end

    // Writer next state; a set in the same cycle as the write keeps the word dirty.
    always_comb begin
        write_d    = 1'b0;
        addr_d     = 32'd0;
        data_d     = 32'd0;
        mask_d     = 4'b0000;
        clr_word_s = '0;
        rr_d       = rr_q;
        if (found_s) begin
            write_d    = 1'b1;
            addr_d     = DISP_BASE + (32'(sel_s) << 2);
            data_d     = sel_data_s;
            mask_d     = sel_mask_s;
            clr_word_s = NUM_WORDS'(1) << sel_s;
            rr_d       = (sel_s == RW'(NUM_WORDS - 1)) ? RW'(0) : (sel_s + RW'(1));
        end else begin
            rr_d = rr_q;
        end
        dirty_d = (dirty_q & ~clr_word_s) | set_s;
    end

    // State and output registers; reset marks every word dirty to initialise the display.
    always_ff @(posedge wClk or negedge nwReset) begin
        if (!nwReset) begin
            keys_q  <= 4'd0;
            run_q   <= 1'b0;
            presc_q <= 17'd0;
            prev_q  <= '0;
            dirty_q <= '1;
            rr_q    <= '0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            mask_q  <= 4'b0000;
            ovf_q   <= 1'b0;
        end else begin
            keys_q  <= keys_d;
            run_q   <= run_d;
            presc_q <= presc_d;
            prev_q  <= prev_d;
            dirty_q <= dirty_d;
            rr_q    <= rr_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wWrite         = write_q;
    assign bWriteAddr     = addr_q;
    assign bWriteData     = data_q;
    assign bWriteMask     = mask_q;
    assign wRead          = 1'b1;
    assign bReadAddr      = KEY_ADDR;
    assign bCountBcd      = count_s;
    assign wCountOverflow = ovf_q;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Directed bench: a 10-digit counter (PRESCALE=1) and a 2-digit counter
// (PRESCALE=4) share clock and reset, driven by independent key words.
module tb_bcd_display_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] keys_a, keys_b;
    logic        wr_a, rd_a, ovf_a, wr_b, rd_b, ovf_b;
    logic [31:0] addr_a, data_a, raddr_a, addr_b, data_b, raddr_b;
    logic [3:0]  mask_a, mask_b;
    logic [39:0] cnt_a;
    logic [7:0]  cnt_b;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    bcd_display_counter #(.NUM_DIGITS(10), .PRESCALE(1)) dut_a (
        .wClk(clk), .nwReset(rst_n), .wWrite(wr_a), .bWriteAddr(addr_a),
        .bWriteData(data_a), .bWriteMask(mask_a), .wRead(rd_a),
        .bReadAddr(raddr_a), .bReadData(keys_a), .bCountBcd(cnt_a),
        .wCountOverflow(ovf_a)
    );

    bcd_display_counter #(.NUM_DIGITS(2), .PRESCALE(4)) dut_b (
        .wClk(clk), .nwReset(rst_n), .wWrite(wr_b), .bWriteAddr(addr_b),
        .bWriteData(data_b), .bWriteMask(mask_b), .wRead(rd_b),
        .bReadAddr(raddr_b), .bReadData(keys_b), .bCountBcd(cnt_b),
        .wCountOverflow(ovf_b)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        keys_a = 32'd0;
        keys_b = 32'd0;
        cyc(2);
        chk("rst_wr_a",   64'(wr_a),   64'd0);
        chk("rst_addr_a", 64'(addr_a), 64'd0);
        chk("rst_data_a", 64'(data_a), 64'd0);
        chk("rst_mask_a", 64'(mask_a), 64'd0);
        chk("rst_cnt_a",  64'(cnt_a),  64'd0);
        chk("rst_ovf_a",  64'(ovf_a),  64'd0);
        chk("rd_a",       64'(rd_a),   64'd1);
        chk("raddr_a",    64'(raddr_a), 64'hF000_0000);

        // Initial display burst after reset release.
        rst_n = 1'b1;
        cyc(1);
        chk("init0_wr",   64'(wr_a),   64'd1);
        chk("init0_addr", 64'(addr_a), 64'hF000_0010);
        chk("init0_data", 64'(data_a), 64'h3F3F_3F3F);
        chk("init0_mask", 64'(mask_a), 64'hF);
        chk("initb_wr",   64'(wr_b),   64'd1);
        chk("initb_data", 64'(data_b), 64'h0000_3F3F);
        chk("initb_mask", 64'(mask_b), 64'h3);
        cyc(1);
        chk("init1_wr",   64'(wr_a),   64'd1);
        chk("init1_addr", 64'(addr_a), 64'hF000_0014);
        chk("init1_data", 64'(data_a), 64'h3F3F_3F3F);
        chk("initb_idle", 64'(wr_b),   64'd0);
        cyc(1);
        chk("init2_wr",   64'(wr_a),   64'd1);
        chk("init2_addr", 64'(addr_a), 64'hF000_0018);
        chk("init2_data", 64'(data_a), 64'h0000_3F3F);
        chk("init2_mask", 64'(mask_a), 64'h3);
        cyc(1);
        chk("init_done",  64'(wr_a),   64'd0);

        // Start for one cycle, stop timed so the count settles at 10.
        keys_a = 32'd4;
        cyc(1);
        keys_a = 32'd0;
        cyc(9);
        keys_a = 32'd2;
        cyc(1);
        keys_a = 32'd0;
        chk("cnt_9",      64'(cnt_a),  64'h9);
        cyc(1);
        chk("cnt_10",     64'(cnt_a),  64'h10);
        cyc(1);
        chk("w10_wr",     64'(wr_a),   64'd1);
        chk("w10_addr",   64'(addr_a), 64'hF000_0010);
        chk("w10_data",   64'(data_a), 64'h3F3F_063F);
        cyc(2);
        chk("w10_quiet",  64'(wr_a),   64'd0);
        chk("cnt_hold",   64'(cnt_a),  64'h10);

        // Clear together with start: clear wins and the counter stays stopped.
        keys_a = 32'd5;
        cyc(1);
        keys_a = 32'd0;
        cyc(1);
        chk("clr_cnt",    64'(cnt_a),  64'h0);
        cyc(3);
        chk("clr_norun",  64'(cnt_a),  64'h0);

        // Running, then stop together with start: stop wins after one more tick.
        keys_a = 32'd4;
        cyc(1);
        keys_a = 32'd6;
        cyc(1);
        keys_a = 32'd0;
        cyc(1);
        chk("ss_cnt",     64'(cnt_a),  64'h1);
        cyc(3);
        chk("ss_norun",   64'(cnt_a),  64'h1);

        // PRESCALE=4: 20 running cycles give 5 ticks; stop and resume mid-period.
        keys_b = 32'd4;
        cyc(1);
        keys_b = 32'd0;
        cyc(20);
        chk("p4_cnt4",    64'(cnt_b),  64'h04);
        cyc(1);
        chk("p4_cnt5",    64'(cnt_b),  64'h05);
        keys_b = 32'd2;
        cyc(1);
        keys_b = 32'd0;
        cyc(4);
        chk("p4_hold",    64'(cnt_b),  64'h05);
        keys_b = 32'd4;
        cyc(1);
        keys_b = 32'd0;
        cyc(2);
        chk("p4_resume0", 64'(cnt_b),  64'h05);
        cyc(1);
        chk("p4_resume1", 64'(cnt_b),  64'h06);

        // Run on to 99 and wrap.
        cyc(375);
        chk("wrap_99",    64'(cnt_b),  64'h99);
        chk("wrap_pre",   64'(ovf_b),  64'd0);
        cyc(1);
        chk("wrap_cnt",   64'(cnt_b),  64'h00);
        chk("wrap_ovf",   64'(ovf_b),  64'd1);
        cyc(1);
        chk("wrap_ovf1",  64'(ovf_b),  64'd0);
        chk("wrap_nowr",  64'(wr_b),   64'd0);
        cyc(1);
        chk("wrap_wr",    64'(wr_b),   64'd1);
        chk("wrap_addr",  64'(addr_b), 64'hF000_0010);
        chk("wrap_data",  64'(data_b), 64'h0000_3F3F);
        chk("wrap_mask",  64'(mask_b), 64'h3);

        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(4);

`ifdef BCD_COUNTER_DOWN_EN
        // Down from zero wraps to 99 with an overflow pulse.
        keys_b = 32'd12;
        cyc(1);
        keys_b = 32'd8;
        cyc(4);
        chk("dn_pre",     64'(cnt_b),  64'h00);
        chk("dn_pre_ovf", 64'(ovf_b),  64'd0);
        cyc(1);
        chk("dn_cnt",     64'(cnt_b),  64'h99);
        chk("dn_ovf",     64'(ovf_b),  64'd1);
        cyc(1);
        chk("dn_ovf1",    64'(ovf_b),  64'd0);
        keys_b = 32'd0;
`endif

        // Reset in the middle of continuous writes clears outputs at once.
        keys_a = 32'd4;
        cyc(1);
        keys_a = 32'd0;
        cyc(4);
        chk("mid_wr",     64'(wr_a),   64'd1);
        chk("mid_cnt",    64'(cnt_a),  64'h3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_wr",    64'(wr_a),   64'd0);
        chk("arst_addr",  64'(addr_a), 64'd0);
        chk("arst_data",  64'(data_a), 64'd0);
        chk("arst_mask",  64'(mask_a), 64'd0);
        chk("arst_cnt",   64'(cnt_a),  64'd0);
        rst_n = 1'b1;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
